// File: rtl/dff_serial_pkg.sv
// dff_serial_pkg: shared types and line-level constants for the serial transmitter.
// The transmitter has one build option, the DFF_SERIAL_TX_PARITY_EN macro. The
// PARITY encoding is always present in the enum so that both builds share one type.
package dff_serial_pkg;

  // Frame sequencing states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Line levels seen by the downstream single-bit sampler
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width needed to count 0..bound-1, never narrower than one bit
  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/dff_bit_timer.sv
// dff_bit_timer: per-bit dwell timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 and raises tick on the terminal count, then wraps.
// clear forces the count back to zero so every state starts a fresh bit period.
// With CLKS_PER_BIT=1 the count is pinned at zero and tick is permanently high.
module dff_bit_timer
  import dff_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Bit-period counter: restarts on clear or terminal count, never passes CNT_LAST
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/dff_serial_tx.sv
// dff_serial_tx: parallel-to-serial frame transmitter.
// Accepts a DATA_W-bit word on a valid/ready handshake and drives a registered
// serial line: start bit, data LSB first, optional even parity, stop bit, each
// held for CLKS_PER_BIT clocks. frame_done pulses for one cycle after the stop bit.
// Build option: define DFF_SERIAL_TX_PARITY_EN to insert the parity bit.
// rst is asynchronous and active-low; while it is low the line sits at idle (1).
module dff_serial_tx
  import dff_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic              tick;
  logic              timer_clear;
  logic              accept;
  logic              shift_now;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [IDX_W-1:0]  idx;
  logic              dout_next;
`ifdef DFF_SERIAL_TX_PARITY_EN
  logic              par_q;
`endif

  assign accept    = din_valid && din_ready;
  assign shift_now = (state == DATA) && tick;

  // Every state gets a full bit period: restart the timer on any state change
  // and keep it parked while idle so START begins at count zero.
  assign timer_clear = (state_next != state) || (state == IDLE);

  dff_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each bit-carrying state advances only on the timer tick
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick && (idx == IDX_LAST)) begin
`ifdef DFF_SERIAL_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef DFF_SERIAL_TX_PARITY_EN
        if (tick) state_next = STOP;
`else
        state_next = IDLE;
`endif
      end
      STOP: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register next value: load on acceptance, shift right once per data bit
  always_comb begin
    shreg_nxt = shreg;
    if (accept) begin
      shreg_nxt = din;
    end else if (shift_now) begin
      shreg_nxt = shreg >> 1;
    end
  end

  // Output logic: handshake, busy flag, and the level the line takes next cycle
  always_comb begin
    din_ready = (state == IDLE) && rst;
    busy      = (state != IDLE);
    dout_next = LINE_IDLE;
    case (state_next)
      IDLE:   dout_next = LINE_IDLE;
      START:  dout_next = START_BIT;
      DATA:   dout_next = shreg_nxt[0];
`ifdef DFF_SERIAL_TX_PARITY_EN
      PARITY: dout_next = par_q;
`endif
      STOP:   dout_next = STOP_BIT;
      default: dout_next = LINE_IDLE;
    endcase
  end

  // Latched word and data-bit index; the word only changes on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      idx   <= '0;
    end else begin
      shreg <= shreg_nxt;
      if ((state != DATA) || (tick && (idx == IDX_LAST))) begin
        idx <= '0;
      end else if (tick) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

`ifdef DFF_SERIAL_TX_PARITY_EN
  // Even parity of the word, captured with the word so later din changes cannot affect it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^din;
    end
  end
`endif

  // Registered line and end-of-frame pulse; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= LINE_IDLE;
      frame_done <= 1'b0;
    end else begin
      dout       <= dout_next;
      frame_done <= (state == STOP) && tick;
    end
  end

endmodule

// File: tb/tb_dff_serial_tx.sv
// tb_dff_serial_tx: directed bench for dff_serial_tx.
// One instance at CLKS_PER_BIT=4 and one at CLKS_PER_BIT=1, both DATA_W=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dff_serial_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef DFF_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = DATA_W + 2 + PAR;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              dout;
  logic              busy;
  logic              frame_done;
  logic [DATA_W-1:0] din1;
  logic              din_valid1;
  logic              din_ready1;
  logic              dout1;
  logic              busy1;
  logic              frame_done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  dff_serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
    .dout(dout1), .busy(busy1), .frame_done(frame_done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame: start, data LSB first, [parity], stop
  function automatic logic [NBITS-1:0] frame_bits(input logic [DATA_W-1:0] w);
    logic [NBITS-1:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) b[1+i] = w[i];
    if (PAR == 1) b[DATA_W+1] = ^w;
    b[NBITS-1] = 1'b1;
    return b;
  endfunction

  // Called at a falling edge where din=w and din_valid=1 are already driven.
  task automatic expect_frame(input logic [DATA_W-1:0] w,
                              input logic [DATA_W-1:0] d_mid, input logic v_mid,
                              input logic [DATA_W-1:0] d_end, input logic v_end);
    logic [NBITS-1:0] bits;
    bits = frame_bits(w);
    @(negedge clk);
    din       = d_mid;
    din_valid = v_mid;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("w%02h_b%0d_c%0d_dout", w, b, c), dout, bits[b]);
        chk($sformatf("w%02h_b%0d_c%0d_busy", w, b, c), busy, 1'b1);
        chk($sformatf("w%02h_b%0d_c%0d_ready", w, b, c), din_ready, 1'b0);
        chk($sformatf("w%02h_b%0d_c%0d_done", w, b, c), frame_done, 1'b0);
        if (!((b == NBITS - 1) && (c == CPB - 1))) @(negedge clk);
      end
    end
    @(negedge clk);
    chk($sformatf("w%02h_end_done", w), frame_done, 1'b1);
    chk($sformatf("w%02h_end_busy", w), busy, 1'b0);
    chk($sformatf("w%02h_end_ready", w), din_ready, 1'b1);
    chk($sformatf("w%02h_end_dout", w), dout, 1'b1);
    din       = d_end;
    din_valid = v_end;
  endtask

  initial begin
    logic [NBITS-1:0] bits1;

    // Reset held with a pending word: nothing may start
    rst        = 1'b0;
    din        = 8'hA5;
    din_valid  = 1'b1;
    din1       = 8'h00;
    din_valid1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_dout", i), dout, 1'b1);
      chk($sformatf("rst%0d_busy", i), busy, 1'b0);
      chk($sformatf("rst%0d_ready", i), din_ready, 1'b0);
      chk($sformatf("rst%0d_done", i), frame_done, 1'b0);
      chk($sformatf("rst%0d_dout1", i), dout1, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk("release_ready", din_ready, 1'b1);

    // Single frame 0xA5, accepted on the first edge after release
    expect_frame(8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("a5_done_once", frame_done, 1'b0);
    chk("a5_idle_dout", dout, 1'b1);

    // 0x07: odd population, parity bit 1 in the parity build
    din       = 8'h07;
    din_valid = 1'b1;
    expect_frame(8'h07, 8'h07, 1'b0, 8'h00, 1'b0);

    // Back-to-back with din_valid held high
    @(negedge clk);
    din       = 8'h3C;
    din_valid = 1'b1;
    expect_frame(8'h3C, 8'h3C, 1'b1, 8'hC3, 1'b1);
    expect_frame(8'hC3, 8'hC3, 1'b0, 8'h00, 1'b0);

    // din/din_valid disturbed during the frame must not alter the latched 0x00
    @(negedge clk);
    din       = 8'h00;
    din_valid = 1'b1;
    expect_frame(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0);

    // Reset during data bit 3 of 0xF0
    @(negedge clk);
    din       = 8'hF0;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("abort_start_dout", dout, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    chk("abort_bit3_dout", dout, 1'b0);
    chk("abort_bit3_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("abort_dout", dout, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", din_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort%0d_done", i), frame_done, 1'b0);
      chk($sformatf("abort%0d_dout", i), dout, 1'b1);
    end
    rst       = 1'b1;
    din       = 8'h5A;
    din_valid = 1'b1;
    expect_frame(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0);

    // One bit per clock on the CLKS_PER_BIT=1 instance
    @(negedge clk);
    chk("cpb1_ready", din_ready1, 1'b1);
    din1       = 8'h81;
    din_valid1 = 1'b1;
    bits1      = frame_bits(8'h81);
    @(negedge clk);
    din_valid1 = 1'b0;
    for (int b = 0; b < NBITS; b++) begin
      chk($sformatf("cpb1_b%0d_dout", b), dout1, bits1[b]);
      chk($sformatf("cpb1_b%0d_busy", b), busy1, 1'b1);
      if (b < NBITS - 1) @(negedge clk);
    end
    @(negedge clk);
    chk("cpb1_done", frame_done1, 1'b1);
    chk("cpb1_end_busy", busy1, 1'b0);
    chk("cpb1_end_dout", dout1, 1'b1);
    @(negedge clk);
    chk("cpb1_done_once", frame_done1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_serial_tx.md
Name: dff_serial_tx

Overview:
- Parallel-to-serial transmitter: the driving end for the single-bit registered serial sampling path (1-bit din captured into dout per clock).
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits a framed serial stream on one output: start bit, data LSB first, optional parity, stop bit.
- Each bit is held for CLKS_PER_BIT clocks, so a downstream single-bit sampler sees stable levels.

Parameters:
- DATA_W, 8, payload width in bits (≥1)
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥1; 1 = one bit per clock)

Ports:
- clk, input, 1, single clock; all state updates on posedge
- rst, input, 1, asynchronous active-low reset
- din, input, DATA_W, parallel word to send
- din_valid, input, 1, din holds a valid word
- din_ready, output, 1, block can accept a word this cycle
- dout, output, 1, registered serial line (idle level 1)
- busy, output, 1, frame in progress
- frame_done, output, 1, one-cycle pulse after the stop bit completes

Behaviour:
- Reset (rst=0, async): state IDLE, dout=1, busy=0, frame_done=0, counters=0, shift reg=0; din_ready=0 while rst=0.
- din_ready = (state==IDLE) && rst deasserted; combinational from state only, never from din_valid.
- Transfer occurs when din_valid && din_ready at a posedge. din is latched into the shift register that edge. State goes to START, dout=0 and busy=1 from the next cycle.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1. Tick on terminal count, then wraps to 0. Reset to 0 on every state entry.
- START: dout=0 for CLKS_PER_BIT cycles; on tick -> DATA.
- DATA: dout = shreg[0]. On tick, shift right by 1 and increment the bit index. On tick with index==DATA_W-1 -> PARITY if enabled, else STOP.
- STOP: dout=1 for CLKS_PER_BIT cycles. On tick -> IDLE, busy=0 and frame_done=1 for exactly that next cycle.
- Back-to-back: din_ready=1 in the same cycle frame_done=1, so acceptance there gives zero idle gap. Frame period = (DATA_W+2[+1])*CLKS_PER_BIT + 1 clocks.
- din/din_valid changes while busy are ignored. The latched word is never modified mid-frame.
- din_valid high in IDLE with stable din must be accepted on the first edge; no extra cycle is inserted.
- Reset mid-frame: immediate abort, dout=1 asynchronously, no frame_done.
- CLKS_PER_BIT=1: timer is a constant tick; each state lasts one cycle.
- Counter widths: $clog2 of the bound, minimum 1 bit. No overflow past the terminal count.

Optional Feature:
- Macro DFF_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. dout = XOR of the latched word (even parity) for CLKS_PER_BIT cycles, then STOP. Parity is computed at acceptance and stored.
- Undefined: no PARITY state, no parity register; DATA goes directly to STOP.

Decomposition:
- Package dff_serial_pkg:
  - state enum typedef tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1
- Sub-module dff_bit_timer: parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick. Instantiated once.

Test Plan:
- Reset: hold rst=0 for 3 cycles with din_valid=1 -> dout=1, busy=0, din_ready=0, frame_done=0. Release rst -> din_ready=1 next cycle, word accepted.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, din=0xA5 -> dout holds 0 | 1,0,1,0,0,1,0,1 | 1, each for 4 cycles (40 cycles total). frame_done pulses once, 1 cycle after the stop bit ends.
- Parity build, din=0xA5 -> parity bit 0 inserted before stop (44 cycles). din=0x07 -> parity bit 1.
- Back-to-back: din_valid held high with 0x3C then 0xC3 -> second start bit begins the cycle after the frame_done cycle. din_ready low throughout each frame.
- Mid-frame disturbance: change din to 0xFF during the DATA bits of 0x00 -> line still sends all zeros. Assert rst during bit 3 -> dout=1 immediately, no frame_done, clean restart afterward.
- CLKS_PER_BIT=1, din=0x81 -> sequence 0,1,0,0,0,0,0,0,1,1 on consecutive cycles.
